// File: rtl/crc_pkg.sv
// Shared types and defaults for the serial CRC path: FSM states, frame geometry and bit order.
// The bit order is also used by the CRC engine and its checker, so they all agree on it.
package crc_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SHIFT    = 2'd1,
      WAIT_CRC = 2'd2
   } crc_state_t;

   localparam int CRC_WORD_W      = 8;
   localparam int CRC_FRAME_WORDS = 2;
   localparam int CRC_GAP_MAX     = 20;
   localparam bit CRC_MSB_FIRST   = 1'b1;

endpackage

// File: rtl/crc_frame_serializer_if.sv
// Word-in / serial-out bundle between the word source, the serializer and the CRC engine.
interface crc_frame_serializer_if
   import crc_pkg::*;
#(
   parameter int WORD_W = CRC_WORD_W
);
   logic [WORD_W-1:0] in_data;
   logic              in_valid;
   logic              in_ready;
   logic              crc_valid;
   logic              DATA;
   logic              Active;
   logic              busy;
   logic              frame_done;
   logic              underrun;

   modport master (
      output in_data, in_valid, crc_valid,
      input  in_ready, DATA, Active, busy, frame_done, underrun
   );

   modport slave (
      input  in_data, in_valid, crc_valid,
      output in_ready, DATA, Active, busy, frame_done, underrun
   );
endinterface

// File: rtl/crc_shift_reg.sv
// Loadable WORD_W shift register; dout is the bit at the leaving end, zeros fill in behind.
module crc_shift_reg
   import crc_pkg::*;
#(
   parameter int WORD_W    = CRC_WORD_W,
   parameter bit MSB_FIRST = CRC_MSB_FIRST
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              shift,
   input  logic [WORD_W-1:0] din,
   output logic              dout
);
   logic [WORD_W-1:0] sr;

   always_ff @(posedge clk) begin
      if (rst) begin
         sr <= '0;
      end else if (load) begin
         sr <= din;
      end else if (shift) begin
         if (MSB_FIRST) sr <= {sr[WORD_W-2:0], 1'b0};
         else           sr <= {1'b0, sr[WORD_W-1:1]};
      end
   end

   assign dout = MSB_FIRST ? sr[WORD_W-1] : sr[0];
endmodule

// File: rtl/crc_frame_serializer.sv
// Serializes FRAME_WORDS words per frame onto DATA/Active (one cycle after acceptance), then waits for the CRC to finish;
// in_ready is only offered in IDLE and on the last bit of a non-final word. CRC_FRAME_SERIALIZER_STATS_EN adds frame/underrun counters.
module crc_frame_serializer
   import crc_pkg::*;
#(
   parameter int WORD_W      = CRC_WORD_W,
   parameter int FRAME_WORDS = CRC_FRAME_WORDS,
   parameter bit MSB_FIRST   = CRC_MSB_FIRST,
   parameter int GAP_MAX     = CRC_GAP_MAX
)(
   input  logic CLK,
   input  logic rst,
   crc_frame_serializer_if.slave bus
`ifdef CRC_FRAME_SERIALIZER_STATS_EN
   ,
   output logic [15:0] frame_cnt,
   output logic [7:0]  underrun_cnt
`endif
);
   localparam int BW = $clog2(WORD_W);
   localparam int WW = $clog2(FRAME_WORDS) + 1;
   localparam int GW = $clog2(GAP_MAX) + 1;
   localparam logic [BW-1:0] BIT_LAST  = BW'(WORD_W - 1);
   localparam logic [WW-1:0] WORD_LAST = WW'(FRAME_WORDS - 1);
   // frame_done is registered, so it is scheduled one count early to land on GAP_MAX-1.
   localparam logic [GW-1:0] GAP_PRE   = GW'(GAP_MAX - 2);

   crc_state_t    state, state_nxt;
   logic [BW-1:0] bit_cnt, bit_nxt;
   logic [WW-1:0] word_cnt, word_nxt;
   logic [GW-1:0] gap_cnt, gap_nxt;
   logic          in_ready_q, active_q, busy_q, frame_done_q, underrun_q;
   logic          crc_valid_d;
   logic          in_ready_nxt, frame_done_nxt, underrun_nxt;
   logic          sr_load, sr_shift, sr_bit;
   logic          handshake;

   assign handshake = bus.in_valid & in_ready_q;

   crc_shift_reg #(
      .WORD_W    (WORD_W),
      .MSB_FIRST (MSB_FIRST)
   ) u_shift_reg (
      .clk   (CLK),
      .rst   (rst),
      .load  (sr_load),
      .shift (sr_shift),
      .din   (bus.in_data),
      .dout  (sr_bit)
   );

   always_comb begin
      state_nxt      = state;
      bit_nxt        = bit_cnt;
      word_nxt       = word_cnt;
      gap_nxt        = gap_cnt;
      sr_load        = 1'b0;
      sr_shift       = 1'b0;
      frame_done_nxt = 1'b0;
      underrun_nxt   = 1'b0;
      case (state)
         IDLE: begin
            if (handshake) begin
               sr_load   = 1'b1;
               bit_nxt   = '0;
               word_nxt  = '0;
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if (bit_cnt == BIT_LAST) begin
               bit_nxt = '0;
               if (word_cnt != WORD_LAST && handshake) begin
                  sr_load  = 1'b1;
                  word_nxt = word_cnt + WW'(1);
               end else begin
                  // Final shift leaves the register all-zero, which keeps DATA low while waiting.
                  sr_shift     = 1'b1;
                  gap_nxt      = '0;
                  state_nxt    = WAIT_CRC;
                  underrun_nxt = (word_cnt != WORD_LAST);
               end
            end else begin
               sr_shift = 1'b1;
               bit_nxt  = bit_cnt + BW'(1);
            end
         end
         WAIT_CRC: begin
            gap_nxt = gap_cnt + GW'(1);
            if (frame_done_q) begin
               state_nxt = IDLE;
               gap_nxt   = '0;
            end else if ((crc_valid_d && !bus.crc_valid) || gap_cnt == GAP_PRE) begin
               frame_done_nxt = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase

      in_ready_nxt = (state_nxt == IDLE) ||
                     (state_nxt == SHIFT && bit_nxt == BIT_LAST && word_nxt != WORD_LAST);
   end

   always_ff @(posedge CLK) begin
      if (rst) begin
         state        <= IDLE;
         bit_cnt      <= '0;
         word_cnt     <= '0;
         gap_cnt      <= '0;
         in_ready_q   <= 1'b0;
         active_q     <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         underrun_q   <= 1'b0;
         crc_valid_d  <= 1'b0;
      end else begin
         state        <= state_nxt;
         bit_cnt      <= bit_nxt;
         word_cnt     <= word_nxt;
         gap_cnt      <= gap_nxt;
         in_ready_q   <= in_ready_nxt;
         active_q     <= (state_nxt == SHIFT);
         busy_q       <= (state_nxt != IDLE);
         frame_done_q <= frame_done_nxt;
         underrun_q   <= underrun_nxt;
         crc_valid_d  <= bus.crc_valid;
      end
   end

   assign bus.in_ready   = in_ready_q;
   assign bus.DATA       = sr_bit;
   assign bus.Active     = active_q;
   assign bus.busy       = busy_q;
   assign bus.frame_done = frame_done_q;
   assign bus.underrun   = underrun_q;

`ifdef CRC_FRAME_SERIALIZER_STATS_EN
   logic aborted;

   always_ff @(posedge CLK) begin
      if (rst) begin
         frame_cnt    <= '0;
         underrun_cnt <= '0;
         aborted      <= 1'b0;
      end else begin
         if (underrun_nxt) begin
            aborted <= 1'b1;
            if (underrun_cnt != 8'hFF) underrun_cnt <= underrun_cnt + 8'd1;
         end
         if (state == WAIT_CRC && frame_done_q) begin
            aborted <= 1'b0;
            if (!aborted) frame_cnt <= frame_cnt + 16'd1;
         end
      end
   end
`endif
endmodule

// File: tb/tb_crc_frame_serializer.sv
// Two serializers (MSB-first and LSB-first) share one stimulus stream; a frame-level model predicts bits and handshakes.
module tb_crc_frame_serializer;
   import crc_pkg::*;

   localparam int W  = 8;
   localparam int FW = 2;
   localparam int GM = 20;

   logic         CLK = 1'b0;
   logic         rst;
   logic [W-1:0] in_data;
   logic         in_valid;
   logic         crc_valid;
   int           checks = 0;
   int           failures = 0;
   int           exp_frames = 0;
   int           exp_unders = 0;

   crc_frame_serializer_if #(.WORD_W(W)) bus_m ();
   crc_frame_serializer_if #(.WORD_W(W)) bus_l ();

   assign bus_m.in_data   = in_data;
   assign bus_m.in_valid  = in_valid;
   assign bus_m.crc_valid = crc_valid;
   assign bus_l.in_data   = in_data;
   assign bus_l.in_valid  = in_valid;
   assign bus_l.crc_valid = crc_valid;

`ifdef CRC_FRAME_SERIALIZER_STATS_EN
   logic [15:0] fc_m, fc_l;
   logic [7:0]  uc_m, uc_l;
`endif

   always #5 CLK = ~CLK;

   crc_frame_serializer #(.WORD_W(W), .FRAME_WORDS(FW), .MSB_FIRST(1'b1), .GAP_MAX(GM)) u_msb (
      .CLK (CLK),
      .rst (rst),
      .bus (bus_m)
`ifdef CRC_FRAME_SERIALIZER_STATS_EN
      , .frame_cnt (fc_m), .underrun_cnt (uc_m)
`endif
   );

   crc_frame_serializer #(.WORD_W(W), .FRAME_WORDS(FW), .MSB_FIRST(1'b0), .GAP_MAX(GM)) u_lsb (
      .CLK (CLK),
      .rst (rst),
      .bus (bus_l)
`ifdef CRC_FRAME_SERIALIZER_STATS_EN
      , .frame_cnt (fc_l), .underrun_cnt (uc_l)
`endif
   );

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Bit i (0 = first on the wire) of a word for the given order.
   function automatic logic ref_bit(input logic [W-1:0] w, input int i, input bit msb);
      return msb ? w[W-1-i] : w[i];
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      crc_valid = 1'b0;
      repeat (2) tick();
      rst = 1'b0;
      exp_frames = 0;
      exp_unders = 0;
   endtask

   // One frame: words w0/w1, handshake withheld after word u_at (-1 = never),
   // crc_valid high for crc_l cycles starting crc_d cycles after Active falls (crc_l=0: never).
   task automatic drive_frame(input string tag, input logic [W-1:0] w0, input logic [W-1:0] w1,
                              input int u_at, input int crc_d, input int crc_l);
      logic [W-1:0] wv [FW];
      logic [4:0]   exp_ctl;
      int           waited;
      bit           aborted;
      int           exp_w;
      wv[0] = w0;
      wv[1] = w1;
      waited = 0;
      while (bus_m.in_ready !== 1'b1 && waited < 40) begin
         tick();
         waited++;
      end
      checks++;
      if (bus_m.in_ready !== 1'b1 || bus_l.in_ready !== 1'b1 || bus_m.busy !== 1'b0) begin
         failures++;
         $display("FAIL %s idle_ready in_ready=%b/%b busy=%b required 1/1 busy=0", tag,
                  bus_m.in_ready, bus_l.in_ready, bus_m.busy);
         return;
      end
      in_data = w0;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;

      aborted = 1'b0;
      for (int k = 0; k < FW && !aborted; k++) begin
         for (int i = 0; i < W; i++) begin
            exp_ctl = {1'b1, 1'b1, (i == W-1 && k < FW-1), 1'b0, 1'b0};
            checks++;
            if ({bus_m.Active, bus_m.busy, bus_m.in_ready, bus_m.frame_done, bus_m.underrun} !== exp_ctl ||
                {bus_l.Active, bus_l.busy, bus_l.in_ready, bus_l.frame_done, bus_l.underrun} !== exp_ctl) begin
               failures++;
               $display("FAIL %s shift_ctl word=%0d bit=%0d act/busy/rdy/done/und=%b,%b required %b", tag, k, i,
                        {bus_m.Active, bus_m.busy, bus_m.in_ready, bus_m.frame_done, bus_m.underrun},
                        {bus_l.Active, bus_l.busy, bus_l.in_ready, bus_l.frame_done, bus_l.underrun}, exp_ctl);
            end
            checks++;
            if (bus_m.DATA !== ref_bit(wv[k], i, 1'b1) || bus_l.DATA !== ref_bit(wv[k], i, 1'b0)) begin
               failures++;
               $display("FAIL %s data word=%0d bit=%0d msb/lsb DATA=%b/%b required %b/%b", tag, k, i,
                        bus_m.DATA, bus_l.DATA, ref_bit(wv[k], i, 1'b1), ref_bit(wv[k], i, 1'b0));
            end
            if (i == W-1 && k < FW-1) begin
               if (u_at == k) begin
                  in_valid = 1'b0;
                  aborted = 1'b1;
               end else begin
                  in_valid = 1'b1;
                  in_data = wv[k+1];
               end
            end else begin
               // Offers outside the ready window must be ignored.
               in_valid = 1'($urandom_range(0, 1));
               in_data = W'($urandom);
            end
            tick();
            in_valid = 1'b0;
         end
      end

      exp_w = GM - 1;
      if (crc_l > 0 && crc_d + crc_l + 1 < exp_w) exp_w = crc_d + crc_l + 1;
      if (aborted) exp_unders++;
      else         exp_frames++;

      for (int w = 0; w <= exp_w; w++) begin
         crc_valid = (crc_l > 0 && w >= crc_d && w < crc_d + crc_l);
         exp_ctl = {1'b0, 1'b1, 1'b0, (w == exp_w), (w == 0 && aborted)};
         checks++;
         if ({bus_m.Active, bus_m.busy, bus_m.in_ready, bus_m.frame_done, bus_m.underrun} !== exp_ctl ||
             {bus_l.Active, bus_l.busy, bus_l.in_ready, bus_l.frame_done, bus_l.underrun} !== exp_ctl ||
             bus_m.DATA !== 1'b0 || bus_l.DATA !== 1'b0) begin
            failures++;
            $display("FAIL %s wait_ctl w=%0d act/busy/rdy/done/und=%b,%b data=%b%b required %b data=00", tag, w,
                     {bus_m.Active, bus_m.busy, bus_m.in_ready, bus_m.frame_done, bus_m.underrun},
                     {bus_l.Active, bus_l.busy, bus_l.in_ready, bus_l.frame_done, bus_l.underrun},
                     bus_m.DATA, bus_l.DATA, exp_ctl);
         end
         tick();
      end
      crc_valid = 1'b0;

      checks++;
      if ({bus_m.busy, bus_m.in_ready, bus_m.frame_done, bus_m.Active} !== 4'b0100 ||
          {bus_l.busy, bus_l.in_ready, bus_l.frame_done, bus_l.Active} !== 4'b0100) begin
         failures++;
         $display("FAIL %s back_to_idle busy/rdy/done/act=%b,%b required 0100", tag,
                  {bus_m.busy, bus_m.in_ready, bus_m.frame_done, bus_m.Active},
                  {bus_l.busy, bus_l.in_ready, bus_l.frame_done, bus_l.Active});
      end
`ifdef CRC_FRAME_SERIALIZER_STATS_EN
      checks++;
      if (fc_m !== 16'(exp_frames) || uc_m !== 8'(exp_unders) || fc_l !== 16'(exp_frames) || uc_l !== 8'(exp_unders)) begin
         failures++;
         $display("FAIL %s stats frame_cnt=%0d/%0d underrun_cnt=%0d/%0d required %0d %0d", tag,
                  fc_m, fc_l, uc_m, uc_l, exp_frames, exp_unders);
      end
`endif
   endtask

   task automatic test_reset();
      int waited;
      rst = 1'b1;
      in_valid = 1'b1;
      in_data = 8'hA5;
      crc_valid = 1'b0;
      repeat (3) tick();
      checks++;
      if ({bus_m.Active, bus_m.busy, bus_m.in_ready, bus_m.frame_done, bus_m.underrun, bus_m.DATA} !== 6'b0 ||
          {bus_l.Active, bus_l.busy, bus_l.in_ready, bus_l.frame_done, bus_l.underrun, bus_l.DATA} !== 6'b0) begin
         failures++;
         $display("FAIL reset_outputs act/busy/rdy/done/und/data=%b,%b required all 0",
                  {bus_m.Active, bus_m.busy, bus_m.in_ready, bus_m.frame_done, bus_m.underrun, bus_m.DATA},
                  {bus_l.Active, bus_l.busy, bus_l.in_ready, bus_l.frame_done, bus_l.underrun, bus_l.DATA});
      end
`ifdef CRC_FRAME_SERIALIZER_STATS_EN
      checks++;
      if (fc_m !== 16'd0 || uc_m !== 8'd0) begin
         failures++;
         $display("FAIL reset_stats frame_cnt=%0d underrun_cnt=%0d required 0 0", fc_m, uc_m);
      end
`endif
      rst = 1'b0;
      in_valid = 1'b0;
      exp_frames = 0;
      exp_unders = 0;
      waited = 0;
      while (bus_m.in_ready !== 1'b1 && waited < 4) begin
         tick();
         waited++;
      end
      checks++;
      if (bus_m.in_ready !== 1'b1 || bus_m.busy !== 1'b0 || bus_m.Active !== 1'b0) begin
         failures++;
         $display("FAIL reset_release in_ready=%b busy=%b Active=%b required 1 0 0",
                  bus_m.in_ready, bus_m.busy, bus_m.Active);
      end
   endtask

   task automatic test_basic_frame();
      drive_frame("basic", 8'hA5, 8'h3C, -1, 2, 8);
   endtask

   task automatic test_lsb_first();
      drive_frame("lsb_first", 8'h01, 8'h80, -1, 0, 0);
   endtask

   task automatic test_underrun();
      drive_frame("underrun", 8'hFF, 8'h00, 0, 0, 0);
   endtask

   task automatic test_reset_mid_frame();
      int waited;
      waited = 0;
      while (bus_m.in_ready !== 1'b1 && waited < 40) begin
         tick();
         waited++;
      end
      in_data = 8'hA5;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (4) tick();
      checks++;
      if (bus_m.Active !== 1'b1 || bus_m.DATA !== ref_bit(8'hA5, 4, 1'b1)) begin
         failures++;
         $display("FAIL mid_rst_pre Active=%b DATA=%b required 1 %b", bus_m.Active, bus_m.DATA,
                  ref_bit(8'hA5, 4, 1'b1));
      end
      rst = 1'b1;
      in_valid = 1'b1;
      in_data = 8'h3C;
      for (int c = 0; c < 2; c++) begin
         tick();
         checks++;
         if ({bus_m.Active, bus_m.busy, bus_m.in_ready, bus_m.DATA} !== 4'b0 ||
             {bus_l.Active, bus_l.busy, bus_l.in_ready, bus_l.DATA} !== 4'b0) begin
            failures++;
            $display("FAIL mid_rst_hold cycle=%0d act/busy/rdy/data=%b,%b required 0000", c,
                     {bus_m.Active, bus_m.busy, bus_m.in_ready, bus_m.DATA},
                     {bus_l.Active, bus_l.busy, bus_l.in_ready, bus_l.DATA});
         end
      end
      rst = 1'b0;
      in_valid = 1'b0;
      exp_frames = 0;
      exp_unders = 0;
      drive_frame("after_rst", 8'hA5, 8'h3C, -1, 2, 8);
   endtask

   task automatic test_back_to_back();
      for (int n = 0; n < 25; n++) begin
         repeat ($urandom_range(0, 2)) tick();
         drive_frame("random", W'($urandom), W'($urandom), ($urandom_range(0, 3) == 0) ? 0 : -1,
                     $urandom_range(0, 13), $urandom_range(0, 10));
      end
   endtask

`ifdef CRC_FRAME_SERIALIZER_STATS_EN
   task automatic test_stats();
      do_reset();
      drive_frame("stats", 8'h11, 8'h22, -1, 1, 3);
      drive_frame("stats", 8'h33, 8'h44, 0, 0, 0);
      drive_frame("stats", 8'h55, 8'h66, -1, 0, 0);
      drive_frame("stats", 8'h77, 8'h88, 0, 3, 2);
      drive_frame("stats", 8'h99, 8'hAA, -1, 4, 5);
      checks++;
      if (fc_m !== 16'd3 || uc_m !== 8'd2) begin
         failures++;
         $display("FAIL stats_total frame_cnt=%0d underrun_cnt=%0d required 3 2", fc_m, uc_m);
      end
   endtask
`endif

   initial begin
      rst = 1'b1;
      in_valid = 1'b0;
      in_data = '0;
      crc_valid = 1'b0;
      test_reset();
      test_basic_frame();
      test_lsb_first();
      test_underrun();
      test_reset_mid_frame();
      test_back_to_back();
`ifdef CRC_FRAME_SERIALIZER_STATS_EN
      test_stats();
`endif
      do_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog simulation time limit reached checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/crc_frame_serializer.md
Name: crc_frame_serializer

Overview:
- Upstream feeder for the serial CRC engine.
- Accepts parallel words over a valid/ready handshake.
- Shifts each frame out as one contiguous bit stream on DATA, with Active high for exactly FRAME_WORDS*WORD_W cycles.
- After each frame it waits for the CRC engine to finish emitting its Valid-qualified CRC, then admits the next frame.

Parameters:
- WORD_W, 8: parallel input word width.
- FRAME_WORDS, 2: words per frame (default frame = 16 bits).
- MSB_FIRST, 1: 1 = word MSB shifted first; 0 = LSB first.
- GAP_MAX, 20: maximum cycles to wait for CRC completion before forcing return to IDLE.

Ports:
- CLK, input, 1: system clock; all logic on its rising edge.
- rst, input, 1: synchronous, active-high reset.
- in_data, input, WORD_W: parallel word.
- in_valid, input, 1: in_data valid.
- in_ready, output, 1: block can accept a word this cycle.
- crc_valid, input, 1: Valid output of the downstream CRC engine.
- DATA, output, 1: serial bit to the CRC engine.
- Active, output, 1: frame-in-progress qualifier to the CRC engine.
- busy, output, 1: high whenever the FSM is not in IDLE.
- frame_done, output, 1: single-cycle pulse when a frame and its CRC window complete.
- underrun, output, 1: single-cycle pulse when a frame is aborted for lack of input.

Behaviour:
- All outputs are registered.
- Reset values: DATA=0, Active=0, busy=0, frame_done=0, underrun=0, in_ready=0 during reset.
- Reset effects: FSM goes to IDLE; shift register, bit counter, word counter and gap counter all go to 0.
- Reset mid-frame discards the partial frame. Active drops on the first edge with rst=1.
- FSM states: IDLE, SHIFT, WAIT_CRC.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: load in_data into the shift register, word_cnt=0, bit_cnt=0, go to SHIFT.
  - Latency: DATA and Active are valid on the cycle after acceptance.
- SHIFT:
  - Active=1.
  - DATA = shift register MSB when MSB_FIRST=1, LSB otherwise.
  - Shift one bit per cycle; bit_cnt counts 0..WORD_W-1.
  - in_ready=1 only during the cycle presenting bit WORD_W-1 of a non-final word.
  - Handshake in that cycle: the next word loads with no bubble, so Active stays continuous.
  - Underrun (no handshake in that cycle): Active=0 next cycle, underrun pulse, go to WAIT_CRC. The frame is abandoned.
  - After bit WORD_W-1 of word FRAME_WORDS-1: Active=0 next cycle, go to WAIT_CRC. in_ready stays 0.
- WAIT_CRC:
  - in_ready=0, Active=0, DATA=0.
  - Gap counter increments each cycle.
  - Exit to IDLE on a falling edge of crc_valid (previous-cycle value 1, current value 0), or when the gap counter reaches GAP_MAX-1, whichever is first.
  - frame_done pulses on the exit cycle (also after an underrun abort).
  - A crc_valid already high on entry still requires its falling edge.
- Simultaneous rst and handshake: rst wins; the word is not consumed.
- Counter widths: bit_cnt = $clog2(WORD_W); word_cnt = $clog2(FRAME_WORDS)+1; gap counter = $clog2(GAP_MAX)+1.
- The FRAME_WORDS=1 boundary is legal: in_ready is never raised in SHIFT.

Optional Feature:
- Macro: CRC_FRAME_SERIALIZER_STATS_EN.
- Defined: adds output frame_cnt[15:0] and output underrun_cnt[7:0].
  - Both reset to 0.
  - frame_cnt increments on each frame_done that was not an underrun abort, and wraps.
  - underrun_cnt increments on each underrun pulse and saturates at 0xFF.
- Undefined: these ports and registers do not exist. All other behaviour is identical.

Decomposition:
- Shared package crc_pkg holds:
  - the state enum typedef (IDLE/SHIFT/WAIT_CRC);
  - localparam defaults for WORD_W, FRAME_WORDS and GAP_MAX;
  - a bit-order constant, shared with the CRC engine and its checker.
- One natural sub-module, crc_shift_reg: a loadable WORD_W shift register with a direction parameter, an output bit, and load/shift enables. The FSM and counters stay in the top module.

Test Plan:
- Reset, then words 0xA5 and 0x3C offered back to back (MSB_FIRST=1):
  - in_ready high in IDLE and in the 8th SHIFT cycle;
  - Active high for exactly 16 cycles starting the cycle after the first acceptance;
  - DATA = 1010_0101_0011_1100;
  - Active then low.
- Same frame; CRC model raises crc_valid 2 cycles after Active falls, holds it 8 cycles, then drops it:
  - frame_done pulses on the cycle crc_valid is seen low;
  - in_ready returns the next cycle;
  - busy is low after that.
- Underrun: accept 0xFF, withhold in_valid during the 8th bit cycle:
  - Active falls after 8 cycles;
  - underrun pulses once;
  - with crc_valid tied 0, frame_done pulses after exactly GAP_MAX=20 WAIT_CRC cycles.
- MSB_FIRST=0 with word 0x01 then 0x80: DATA = 1000_0000_0000_0001.
- Assert rst during the 5th bit of the first word:
  - next cycle Active=0, busy=0, in_ready=0 while rst is high;
  - after rst falls, a fresh 0xA5/0x3C frame serializes correctly from bit 0.
- With CRC_FRAME_SERIALIZER_STATS_EN: run 3 good frames and 2 underruns; expect frame_cnt=3, underrun_cnt=2.
